led_sequencer: RTL and testbench

Pattern-sequencer stage that sits directly downstream of the rate counter and consumes its `o_enable` strobe as a step tick. On each accepted tick it advances an NB_LEDS-wide LED pattern according to a selected mode: rotate left, rotate right, ping-pong or flash. It is the visible output stage of the introductory counter chain and drives the board LEDs directly.

---
 rtl/led_sequencer_pkg.sv | 20 ++
 rtl/led_sequencer.sv | 121 ++++++++++++
 tb/tb_led_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared encodings for the LED pattern sequencer: mode select values,
// FSM state codes and the pattern loaded at reset.
package led_sequencer_pkg;

  localparam logic [1:0] MODE_LEFT     = 2'b00;
  localparam logic [1:0] MODE_RIGHT    = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_FLASH    = 2'b11;

  typedef enum logic [1:0] {
    S_LEFT      = 2'b00,
    S_RIGHT     = 2'b01,
    S_FLASH_OFF = 2'b10,
    S_FLASH_ON  = 2'b11
  } state_t;

  // Wide enough for the largest legal pattern; sliced to NB_LEDS by the user.
  localparam logic [15:0] RESET_PATTERN = 16'h0001;

endpackage

// File: rtl/led_sequencer.sv
// Steps an NB_LEDS-wide LED pattern on each accepted tick, in rotate-left,
// rotate-right, ping-pong or flash mode. All outputs are registered.
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int NB_LEDS = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_run,
  input  logic [1:0]         i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_dir,
  output logic               o_wrap
);

  localparam logic [NB_LEDS-1:0] LSB_HOT  = RESET_PATTERN[NB_LEDS-1:0];
  localparam logic [NB_LEDS-1:0] MSB_HOT  = {1'b1, {(NB_LEDS-1){1'b0}}};
  localparam logic [NB_LEDS-1:0] ALL_ON   = {NB_LEDS{1'b1}};
  localparam logic [NB_LEDS-1:0] ALL_OFF  = {NB_LEDS{1'b0}};

  state_t             state, state_nxt;
  logic [NB_LEDS-1:0] led_nxt;
  logic               dir_nxt;
  logic               wrap_nxt;
  logic               in_flash;
  logic [NB_LEDS-1:0] rot_left;
  logic [NB_LEDS-1:0] rot_right;

  assign in_flash  = (state == S_FLASH_OFF) || (state == S_FLASH_ON);
  assign rot_left  = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
  assign rot_right = {o_led[0], o_led[NB_LEDS-1:1]};

  always_comb begin
    state_nxt = state;
    led_nxt   = o_led;
    dir_nxt   = o_dir;
    wrap_nxt  = 1'b0;
    if (i_tick && i_run) begin
      unique case (i_mode)
        MODE_LEFT: begin
          state_nxt = S_LEFT;
          dir_nxt   = 1'b0;
          if (in_flash) begin
            led_nxt = LSB_HOT;
          end else begin
            led_nxt  = rot_left;
            wrap_nxt = o_led[NB_LEDS-1];
          end
        end
        MODE_RIGHT: begin
          state_nxt = S_RIGHT;
          dir_nxt   = 1'b1;
          if (in_flash) begin
            led_nxt = MSB_HOT;
          end else begin
            led_nxt  = rot_right;
            wrap_nxt = o_led[0];
          end
        end
        MODE_PINGPONG: begin
          // Bounce at the ends without dwelling: reversal and move share one step.
          if (in_flash) begin
            state_nxt = S_LEFT;
            led_nxt   = LSB_HOT;
            dir_nxt   = 1'b0;
          end else if (state == S_LEFT) begin
            if (o_led[NB_LEDS-1]) begin
              state_nxt = S_RIGHT;
              led_nxt   = o_led >> 1;
              dir_nxt   = 1'b1;
              wrap_nxt  = 1'b1;
            end else begin
              led_nxt = o_led << 1;
              dir_nxt = 1'b0;
            end
          end else begin
            if (o_led[0]) begin
              state_nxt = S_LEFT;
              led_nxt   = o_led << 1;
              dir_nxt   = 1'b0;
              wrap_nxt  = 1'b1;
            end else begin
              led_nxt = o_led >> 1;
              dir_nxt = 1'b1;
            end
          end
        end
        MODE_FLASH: begin
          if (state == S_FLASH_OFF) begin
            state_nxt = S_FLASH_ON;
            led_nxt   = ALL_ON;
            wrap_nxt  = 1'b1;
          end else if (state == S_FLASH_ON) begin
            state_nxt = S_FLASH_OFF;
            led_nxt   = ALL_OFF;
          end else begin
            state_nxt = S_FLASH_ON;
            led_nxt   = ALL_ON;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state  <= S_LEFT;
      o_led  <= LSB_HOT;
      o_dir  <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_led  <= led_nxt;
      o_dir  <= dir_nxt;
      o_wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: each driven cycle queues its hand-computed
// expected outputs, and a monitor compares them one cycle later.
module tb_led_sequencer;

  logic       clock;
  logic       i_reset;
  logic       i_tick;
  logic       i_run;
  logic [1:0] i_mode;
  logic [3:0] o_led;
  logic       o_dir;
  logic       o_wrap;

  typedef struct {
    string      name;
    logic [3:0] led;
    logic       dir;
    logic       wrap;
  } expect_t;

  expect_t scoreboard[$];
  int      tests_run = 0;
  int      tests_failed = 0;

  led_sequencer #(.NB_LEDS(4)) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .i_tick (i_tick),
    .i_run  (i_run),
    .i_mode (i_mode),
    .o_led  (o_led),
    .o_dir  (o_dir),
    .o_wrap (o_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; results are checked just after the rising edge.
  task automatic applyStimulus(input string name, input logic rst, input logic tick,
                               input logic run, input logic [1:0] mode,
                               input logic [3:0] exp_led, input logic exp_dir,
                               input logic exp_wrap);
    expect_t e;
    @(negedge clock);
    i_reset = rst;
    i_tick  = tick;
    i_run   = run;
    i_mode  = mode;
    e.name  = name;
    e.led   = exp_led;
    e.dir   = exp_dir;
    e.wrap  = exp_wrap;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    tests_run++;
    if (o_led !== e.led || o_dir !== e.dir || o_wrap !== e.wrap) begin
      tests_failed++;
      $display("[TB] FAIL %s: got led=%b dir=%b wrap=%b, want led=%b dir=%b wrap=%b",
               e.name, o_led, o_dir, o_wrap, e.led, e.dir, e.wrap);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
  end

  initial begin
    i_reset = 1'b1;
    i_tick  = 1'b0;
    i_run   = 1'b1;
    i_mode  = 2'b00;

    applyStimulus("reset",      1, 0, 1, 2'b00, 4'b0001, 0, 0);

    applyStimulus("left1",      0, 1, 1, 2'b00, 4'b0010, 0, 0);
    applyStimulus("left2",      0, 1, 1, 2'b00, 4'b0100, 0, 0);
    applyStimulus("left3",      0, 1, 1, 2'b00, 4'b1000, 0, 0);
    applyStimulus("left_wrap",  0, 1, 1, 2'b00, 4'b0001, 0, 1);
    applyStimulus("left5",      0, 1, 1, 2'b00, 4'b0010, 0, 0);

    applyStimulus("reset2",     1, 0, 1, 2'b00, 4'b0001, 0, 0);
    applyStimulus("right_wrap", 0, 1, 1, 2'b01, 4'b1000, 1, 1);
    applyStimulus("wrap_1cyc",  0, 0, 1, 2'b01, 4'b1000, 1, 0);
    applyStimulus("right2",     0, 1, 1, 2'b01, 4'b0100, 1, 0);

    applyStimulus("reset3",     1, 0, 1, 2'b00, 4'b0001, 0, 0);
    applyStimulus("pp1",        0, 1, 1, 2'b10, 4'b0010, 0, 0);
    applyStimulus("pp2",        0, 1, 1, 2'b10, 4'b0100, 0, 0);
    applyStimulus("pp3",        0, 1, 1, 2'b10, 4'b1000, 0, 0);
    applyStimulus("pp_top",     0, 1, 1, 2'b10, 4'b0100, 1, 1);
    applyStimulus("pp5",        0, 1, 1, 2'b10, 4'b0010, 1, 0);
    applyStimulus("pp6",        0, 1, 1, 2'b10, 4'b0001, 1, 0);
    applyStimulus("pp_bottom",  0, 1, 1, 2'b10, 4'b0010, 0, 1);

    applyStimulus("flash_on",   0, 1, 1, 2'b11, 4'b1111, 0, 0);
    applyStimulus("flash_off",  0, 1, 1, 2'b11, 4'b0000, 0, 0);
    applyStimulus("flash_wrap", 0, 1, 1, 2'b11, 4'b1111, 0, 1);
    applyStimulus("reload_l",   0, 1, 1, 2'b00, 4'b0001, 0, 0);
    applyStimulus("flash_on2",  0, 1, 1, 2'b11, 4'b1111, 0, 0);
    applyStimulus("reload_r",   0, 1, 1, 2'b01, 4'b1000, 1, 0);

    for (int i = 0; i < 10; i++)
      applyStimulus("run_off",  0, 1, 0, 2'b00, 4'b1000, 1, 0);
    applyStimulus("no_tick",    0, 0, 1, 2'b00, 4'b1000, 1, 0);
    applyStimulus("resume",     0, 1, 1, 2'b01, 4'b0100, 1, 0);

    applyStimulus("mode_idle1", 0, 0, 1, 2'b00, 4'b0100, 1, 0);
    applyStimulus("mode_r",     0, 1, 1, 2'b01, 4'b0010, 1, 0);
    applyStimulus("mode_idle2", 0, 0, 1, 2'b11, 4'b0010, 1, 0);
    applyStimulus("mode_l",     0, 1, 1, 2'b00, 4'b0100, 0, 0);
    applyStimulus("mode_idle3", 0, 0, 1, 2'b11, 4'b0100, 0, 0);
    applyStimulus("mode_pp",    0, 1, 1, 2'b10, 4'b1000, 0, 0);
    applyStimulus("mode_pp2",   0, 1, 1, 2'b10, 4'b0100, 1, 1);

    applyStimulus("reset_wins", 1, 1, 1, 2'b10, 4'b0001, 0, 0);

    @(negedge clock);
    i_reset = 1'b0;
    i_tick  = 1'b0;
    for (int i = 0; i < 10 && scoreboard.size() > 0; i++) @(negedge clock);
    if (scoreboard.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", scoreboard.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
